// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
// Drives the PWM generator's 8-bit duty value. It ramps from the current duty
// toward a latched goal in fixed steps, with a programmable dwell between steps.
// Mode 0 is a one-shot fade that ends with a done pulse. Mode 1 "breathes"
// continuously between the target and zero until stop is asserted.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE and
// only when stop is low in the same cycle. stop is honoured in every state and
// wins over any step or arrival at the same edge. There is no ready signal;
// busy reports that a ramp is in progress, and start is ignored while busy.
module pwm_ramp_controller #(
    parameter int DWELL_W = 16
) (
    input  logic               cclk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         target,
    input  logic [7:0]         step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         duty_cycle,
    output logic               busy,
    output logic               done,
    output logic               dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         duty_q, duty_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [7:0]         goal_q, goal_d;
    logic               mode_q, mode_d;
    logic [7:0]         target_q, target_d;
    logic [7:0]         step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    // Step arithmetic signals, all derived from registered values only.
    logic [8:0] diff;
    logic       going_up;
    logic       arrive;

    // Distance to the goal and the arrival test, widened to 9 bits.
    always_comb begin
        going_up = (goal_q > duty_q);
        if (going_up) begin
            diff = {1'b0, goal_q} - {1'b0, duty_q};
        end else begin
            diff = {1'b0, duty_q} - {1'b0, goal_q};
        end
        arrive = (diff <= {1'b0, step_q});
    end

    // State register and every datapath register, with synchronous reset.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= 8'd0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            goal_q   <= 8'd0;
            mode_q   <= 1'b0;
            target_q <= 8'd0;
            step_q   <= 8'd0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            goal_q   <= goal_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
        end
    end

    // Next-state and next-datapath logic. Everything holds by default, and done
    // is a pulse, so it defaults to low.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        goal_d   = goal_q;
        mode_d   = mode_q;
        target_d = target_q;
        step_d   = step_q;
        dwell_d  = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    // Breathing toward zero is meaningless, so a zero target
                    // degrades breathe into a one-shot ramp down.
                    mode_d   = mode && (target != 8'd0);
                    target_d = target;
                    step_d   = (step == 8'd0) ? 8'd1 : step;
                    dwell_d  = dwell;
                    goal_d   = target;
                    if (!(mode && (target != 8'd0)) && (duty_q == target)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                        cnt_d   = dwell;
                    end
                end
            end

            ST_RAMP: begin
                if (stop) begin
                    // Abort: duty freezes where it is and no done is raised.
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (arrive) begin
                        duty_d = goal_q;
                        if (mode_q) begin
                            goal_d = (goal_q != 8'd0) ? 8'd0 : target_q;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (going_up) begin
                        // diff > step, so this sum stays strictly below goal.
                        duty_d = duty_q + step_q;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs come straight from registers.
    assign duty_cycle = duty_q;
    assign busy       = (state_q == ST_RAMP);
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller. Expected values are worked out by hand
// from the ramp timing: the first step lands dwell+1 edges after start, and each
// later step lands dwell+1 edges after the previous one.
module tb_pwm_ramp_controller;

    localparam int DWELL_W = 16;

    logic               cclk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               mode;
    logic [7:0]         target;
    logic [7:0]         step;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         duty_cycle;
    logic               busy;
    logic               done;
    logic               dbg_state;

    int checks = 0;
    int errors = 0;

    pwm_ramp_controller #(.DWELL_W(DWELL_W)) dut (
        .cclk       (cclk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .target     (target),
        .step       (step),
        .dwell      (dwell),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Advance one rising edge, then settle so that outputs are sampled away from it.
    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input int b, input int dn);
        chk({tag, ".duty"}, int'(duty_cycle), d);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), dn);
    endtask

    // Pulse start for one edge with the given parameters.
    task automatic do_start(input logic m, input logic [7:0] t, input logic [7:0] s,
                            input logic [DWELL_W-1:0] dw);
        mode   = m;
        target = t;
        step   = s;
        dwell  = dw;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin : stim
        int exp_d [4];
        int brth [6];
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        target = 8'd0; step = 8'd0; dwell = '0;
        tick();
        tick();
        chk_out("reset", 0, 0, 0);
        chk("reset.state", int'(dbg_state), 0);
        rst = 1'b0;
        tick();
        chk_out("post_reset", 0, 0, 0);

        // Fade 0 -> 10, step 3, dwell 2. Steps land at N+3, N+6, N+9, N+12.
        exp_d = '{3, 6, 9, 10};
        do_start(1'b0, 8'd10, 8'd3, 16'd2);
        chk_out("fade.N", 0, 1, 0);
        chk("fade.N.state", int'(dbg_state), 1);
        // The live inputs change freely; only the latched copies may be used.
        target = 8'd200; step = 8'd50; dwell = 16'd7;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) begin
                // This start arrives while busy and must be ignored.
                start = 1'b1;
            end
            chk_out("fade.dwell1", exp_d[k] - ((k == 0) ? 3 : 3 - ((k == 3) ? 2 : 0)) , 1, 0);
            tick();
            start = 1'b0;
            chk("fade.dwell2.duty", int'(duty_cycle), (k == 0) ? 0 : ((k == 3) ? 9 : exp_d[k] - 3));
            tick();
            chk("fade.step.duty", int'(duty_cycle), exp_d[k]);
            chk("fade.step.busy", int'(busy), (k == 3) ? 0 : 1);
            chk("fade.step.done", int'(done), (k == 3) ? 1 : 0);
        end
        tick();
        chk_out("fade.after", 10, 0, 0);

        // 10 -> 0 with step 0, which behaves as step 1, and dwell 0.
        do_start(1'b0, 8'd0, 8'd0, 16'd0);
        chk_out("down.N", 10, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_out("down.step", 10 - k, (k == 10) ? 0 : 1, (k == 10) ? 1 : 0);
        end

        // Saturation upward: 200, then exactly 255 with no wrap.
        do_start(1'b0, 8'd255, 8'd200, 16'd0);
        tick();
        chk_out("sat_up.1", 200, 1, 0);
        tick();
        chk_out("sat_up.2", 255, 0, 1);
        // A new start is accepted in the same cycle that done is high.
        do_start(1'b0, 8'd0, 8'd100, 16'd0);
        chk_out("sat_dn.N", 255, 1, 0);
        tick();
        chk_out("sat_dn.1", 155, 1, 0);
        tick();
        chk_out("sat_dn.2", 55, 1, 0);
        tick();
        chk_out("sat_dn.3", 0, 0, 1);

        // Breathe 0 <-> 4, step 2, dwell 0.
        brth = '{2, 4, 2, 0, 2, 4};
        do_start(1'b1, 8'd4, 8'd2, 16'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out("breathe", brth[k], 1, 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("breathe.stop", 4, 0, 0);
        tick();
        chk_out("breathe.idle", 4, 0, 0);

        // A stop on a step edge: 4 -> 9 lands at N+2; the next step would land at N+4.
        do_start(1'b0, 8'd20, 8'd5, 16'd1);
        tick();
        chk_out("stopstep.N1", 4, 1, 0);
        tick();
        chk_out("stopstep.N2", 9, 1, 0);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stopstep.N4", 9, 0, 0);

        // A stop in IDLE suppresses a start in the same cycle.
        stop = 1'b1;
        do_start(1'b0, 8'd50, 8'd1, 16'd0);
        stop = 1'b0;
        chk_out("idle_stop", 9, 0, 0);
        tick();
        chk_out("idle_stop.2", 9, 0, 0);

        // A start toward the current duty: done at once, busy never asserted.
        do_start(1'b0, 8'd9, 8'd4, 16'd3);
        chk_out("same.N", 9, 0, 1);
        tick();
        chk_out("same.N1", 9, 0, 0);

        // Breathe toward a zero target degrades to a one-shot ramp down.
        do_start(1'b1, 8'd0, 8'd9, 16'd0);
        chk_out("brz.N", 9, 1, 0);
        tick();
        chk_out("brz.1", 0, 0, 1);
        tick();
        chk_out("brz.2", 0, 0, 0);

        // Reset mid-ramp at duty=6 with the dwell counter at 1.
        do_start(1'b0, 8'd10, 8'd3, 16'd2);
        for (int k = 0; k < 7; k++) tick();
        chk_out("rst_mid.pre", 6, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rst_mid", 0, 0, 0);
        do_start(1'b0, 8'd2, 8'd1, 16'd0);
        chk_out("rst_new.N", 0, 1, 0);
        tick();
        chk_out("rst_new.1", 1, 1, 0);
        tick();
        chk_out("rst_new.2", 2, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencer that drives the 8-bit `duty_cycle` input of the PWM generator, ramping it from its current value toward a programmed target in fixed steps with a programmable dwell between steps. It supports a one-shot ramp (fade) and a continuous breathe mode that bounces between the target and zero. It sits between the control/register logic and the PWM generator, replacing a static duty-cycle register.

## Interface
- `DWELL_W`, default 16: width of the dwell counter and `dwell` input.
- `cclk  input  1`: system clock; all logic is on its rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `start  input  1`: single-cycle request to begin a ramp. It is sampled only in IDLE and ignored while busy.
- `stop  input  1`: abort request. It is honoured in any state.
- `mode  input  1`: 0 selects a one-shot ramp; 1 selects breathe. Latched on accepted `start`.
- `target  input  8`: goal duty. Latched on accepted `start`.
- `step  input  8`: duty increment per step. Latched on accepted `start`; a value of 0 is treated as 1.
- `dwell  input  DWELL_W`: extra cycles between steps. Latched on accepted `start`.
- `duty_cycle  output  8`: registered duty value sent to the PWM generator.
- `busy  output  1`: high while in RAMP.
- `done  output  1`: one-cycle pulse when a one-shot ramp completes.

## Operation
- Reset values: state=IDLE, `duty_cycle`=0, `busy`=0, `done`=0, dwell counter=0, goal=0, all latches=0.
- IDLE state:
  - `duty_cycle` holds its value.
  - An accepted `start` latches mode, target, step (0→1) and dwell, and sets goal=target.
  - If mode=0 and `duty_cycle`==target: stay in IDLE and pulse `done` at the same edge.
  - If mode=1 and target==0: behave as mode=0.
  - Otherwise: go to RAMP and load the counter with `dwell`.
- RAMP state, at each edge:
  - If counter≠0: decrement the counter.
  - If counter==0: take one step and reload the counter with the latched dwell.
- Step arithmetic:
  - Compute the difference |goal−duty| in 9 bits.
  - If the difference ≤ step: `duty_cycle`←goal (arrival).
  - Otherwise: `duty_cycle`←duty±step, toward goal.
  - `duty_cycle` never wraps or overshoots; 255 and 0 are reached exactly.
- Arrival, mode 0: go to IDLE and pulse `done` at the same edge.
- Arrival, mode 1: goal toggles between the latched target and 0. The state stays RAMP, no `done` is produced, and the counter is reloaded.
- `stop`:
  - In RAMP: go to IDLE, `duty_cycle` holds its current value, no `done`.
  - `stop` takes priority over a simultaneous step or arrival at the same edge; the step is not applied.
  - In IDLE: `stop` also suppresses a `start` in the same cycle.
- `rst` overrides everything, including mid-ramp. `duty_cycle` returns to 0 immediately.
- Inputs other than `start`/`stop` may change freely while busy; only the latched copies are used.

## Timing
- `start` accepted at edge N: `busy`=1 from edge N.
- Step timing:
  - First step lands at edge N+dwell+1.
  - Later steps land every dwell+1 cycles.
  - With dwell=0, a step lands on every edge.
- One-shot ramp from d0 to t: k=ceil(|t−d0|/step) steps.
  - Arrival is at edge N+k·(dwell+1).
  - `done`=1 and `busy`=0 are both visible after that edge, in the same cycle as the final `duty_cycle`.
- `done` is high for exactly one cycle. A new `start` is accepted in the cycle `done` is high, since the state is IDLE.
- `start` with `duty_cycle`==target (mode 0): `done` rises at edge N, `busy` stays 0.
- Breathe period: (ceil(target/step)·2)·(dwell+1) cycles, measured after the first arrival at target.
- `stop` at edge M: `busy`=0 after edge M, and `duty_cycle` equals its value before edge M.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with mode=0, target=10, step=3, dwell=2:
  - `duty_cycle` reads 3, 6, 9, 10.
  - Steps land at edges N+3, N+6, N+9, N+12.
  - `done` pulses once at N+12; `busy` drops at the same edge.
- From duty=10, `start` with target=0, step=0, dwell=0: duty decrements by 1 per cycle to 0 (step 0 treated as 1), and `done` fires after 10 cycles.
- Saturation:
  - From 0, target=255, step=200, dwell=0: duty reads 200, then 255, with no wrap.
  - Then target=0, step=100: duty reads 155, 55, 0.
- Breathe, mode=1, target=4, step=2, dwell=0:
  - Duty repeats 2, 4, 2, 0, 2, 4, …
  - `done` never asserts.
  - `stop` asserted when duty=4 leaves duty=4, `busy`=0.
- `start` pulsed while busy is ignored. After a `stop` that coincides with a step edge, duty is unchanged. `start` with `duty_cycle`==target and mode=0 gives `done` with `busy` never asserted.
- `rst` asserted mid-ramp (duty=6, counter=1): the next cycle shows duty=0, `busy`=0, `done`=0, and a new `start` works normally.
